// File: rtl/megarom_pkg.sv
// Shared types, constants and address helpers for the MegaROM bank mapper.
package megarom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRIVE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int          NUM_BANKS      = 4;
  localparam logic [15:0] PAGE_LO        = 16'h4000;
  localparam logic [15:0] PAGE_HI        = 16'hC000;
  localparam int          BANK_SHIFT_8K  = 13;
  localparam int          BANK_SHIFT_16K = 14;

  // 8 KB banks split each page in two on ADDR[13]; 16 KB banks are one per page.
  function automatic logic [1:0] bank_index(input logic [15:0] addr, input logic is_16k);
    return is_16k ? {1'b0, addr[15]} : {addr[15], addr[13]};
  endfunction

  function automatic logic [21:0] bank_offset(input logic [7:0] bank, input logic [13:0] low,
                                              input logic is_16k);
    logic [21:0] b;
    b = {14'd0, bank};
    if (is_16k)
      return (b << BANK_SHIFT_16K) | {8'd0, low};
    return (b << BANK_SHIFT_8K) | {9'd0, low[12:0]};
  endfunction

endpackage

// File: rtl/megarom_bank_regs.sv
// Four MegaROM bank registers: address-match loading on slot writes and
// reload from the init values while the MSX bus reset is asserted.
module megarom_bank_regs
  import megarom_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_reset_n,
  input  logic        wr_en,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic [63:0] bank_reg_addr,
  input  logic [15:0] bank_reg_addr_mask,
  input  logic [7:0]  bank_reg_mask,
  input  logic [31:0] bank_reg_init,
  output logic [31:0] banks
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [7:0] bank_reg;
      logic       hit;

      // Several banks may decode the same address; each one that hits loads.
      assign hit = ((addr ^ bank_reg_addr[gi*16 +: 16]) & ~bank_reg_addr_mask) == 16'd0;

      always_ff @(posedge clk) begin
        if (!reset_n)
          bank_reg <= 8'd0;
        else if (!bus_reset_n)
          bank_reg <= bank_reg_init[gi*8 +: 8];
        else if (wr_en && hit)
          bank_reg <= din & bank_reg_mask;
      end

      assign banks[gi*8 +: 8] = bank_reg;
    end
  endgenerate

endmodule

// File: rtl/megarom_mapper.sv
// MSX MegaROM bank mapper and cartridge RAM access sequencer.
// Optional Z80 WAIT stretching on reads is enabled by defining MEGAROM_WAIT_EN.
module megarom_mapper
  import megarom_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 24
) (
  input  logic                      CLK,
  input  logic                      RESET_n,
  // MSX slot bus
  input  logic [15:0]               bus_addr,
  input  logic [7:0]                bus_din,
  output logic [7:0]                bus_dout,
  input  logic                      bus_sltsl_n,
  input  logic                      bus_merq_n,
  input  logic                      bus_rd_n,
  input  logic                      bus_wr_n,
  input  logic                      bus_reset_n,
  output logic                      bus_busdir_n,
  output logic                      bus_wait_n,
  output logic                      bus_int_n,
  // MegaROM configuration
  input  logic [63:0]               bank_reg_addr,
  input  logic [15:0]               bank_reg_addr_mask,
  input  logic [7:0]                bank_reg_mask,
  input  logic [31:0]               bank_reg_init,
  input  logic                      write_protect,
  input  logic                      is_16k_bank,
  input  logic                      cs1_mask,
  input  logic                      cs2_mask,
  input  logic [MEM_ADDR_WIDTH-1:0] memory_top_addr,
  // Cartridge RAM port
  output logic                      MEM_REQ,
  output logic                      MEM_WE,
  output logic [MEM_ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [7:0]                MEM_WDATA,
  input  logic                      MEM_ACK,
  input  logic [7:0]                MEM_RDATA
);

  state_t                    state_reg, state_next;
  logic                      rd_n, wr_n, rd_n_reg, wr_n_reg;
  logic                      det_rd, det_wr;
  logic                      page_live, start_rd, start_wr, driving;
  logic [31:0]               banks;
  logic [1:0]                idx;
  logic [7:0]                cur_bank;
  logic [MEM_ADDR_WIDTH-1:0] target_addr;
  logic                      req_reg, req_next, we_reg, we_next;
  logic                      abort_reg, abort_next;
  logic [MEM_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [7:0]                wdata_reg, wdata_next, rdata_reg, rdata_next;

  assign rd_n   = bus_sltsl_n | bus_merq_n | bus_rd_n;
  assign wr_n   = bus_sltsl_n | bus_merq_n | bus_wr_n;
  assign det_rd = rd_n_reg & ~rd_n;
  assign det_wr = wr_n_reg & ~wr_n;

  assign page_live = (bus_addr >= PAGE_LO) && (bus_addr < PAGE_HI) &&
                     !(bus_addr[15] ? cs2_mask : cs1_mask);

  // Accesses are not started while the MSX bus is held in reset.
  assign start_rd = (state_reg == ST_IDLE) && bus_reset_n && det_rd && page_live;
  assign start_wr = (state_reg == ST_IDLE) && bus_reset_n && det_wr && page_live && !write_protect;

  megarom_bank_regs u_bank_regs (
    .clk                (CLK),
    .reset_n            (RESET_n),
    .bus_reset_n        (bus_reset_n),
    .wr_en              (det_wr && page_live),
    .addr               (bus_addr),
    .din                (bus_din),
    .bank_reg_addr      (bank_reg_addr),
    .bank_reg_addr_mask (bank_reg_addr_mask),
    .bank_reg_mask      (bank_reg_mask),
    .bank_reg_init      (bank_reg_init),
    .banks              (banks)
  );

  assign idx         = bank_index(bus_addr, is_16k_bank);
  assign cur_bank    = banks[{idx, 3'b000} +: 8];
  // Modular add: the result wraps at the top of the cartridge address space.
  assign target_addr = memory_top_addr +
                       MEM_ADDR_WIDTH'(bank_offset(cur_bank, bus_addr[13:0], is_16k_bank));

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_reg <= ST_IDLE;
      rd_n_reg  <= 1'b1;
      wr_n_reg  <= 1'b1;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      abort_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 8'd0;
      rdata_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      rd_n_reg  <= rd_n;
      wr_n_reg  <= wr_n;
      req_reg   <= req_next;
      we_reg    <= we_next;
      abort_reg <= abort_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    abort_next = abort_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    case (state_reg)
      ST_IDLE: begin
        abort_next = 1'b0;
        if (start_rd || start_wr) begin
          state_next = ST_REQ;
          req_next   = 1'b1;
          we_next    = start_wr;
          addr_next  = target_addr;
          if (start_wr)
            wdata_next = bus_din;
        end
      end
      ST_REQ: begin
        // A bus reset cannot cancel the handshake, only its result.
        if (!bus_reset_n)
          abort_next = 1'b1;
        if (MEM_ACK) begin
          req_next = 1'b0;
          if (abort_reg || !bus_reset_n) begin
            state_next = ST_IDLE;
          end else if (we_reg) begin
            state_next = ST_HOLD;
          end else begin
            rdata_next = MEM_RDATA;
            state_next = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: if (rd_n || !bus_reset_n) state_next = ST_IDLE;
      ST_HOLD:  if (wr_n || !bus_reset_n) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign driving      = (state_reg == ST_DRIVE) && bus_reset_n;
  assign bus_dout     = driving ? rdata_reg : 8'h00;
  assign bus_busdir_n = ~driving;
  assign bus_int_n    = 1'b1;

`ifdef MEGAROM_WAIT_EN
  assign bus_wait_n = ~(start_rd || ((state_reg == ST_REQ) && !we_reg));
`else
  assign bus_wait_n = 1'b1;
`endif

  assign MEM_REQ   = req_reg;
  assign MEM_WE    = we_reg;
  assign MEM_ADDR  = addr_reg;
  assign MEM_WDATA = wdata_reg;

endmodule
